mdu: RTL and testbench
======================

# mdu

Iterative RV32M multiply/divide unit sitting beside the `alu` in the EX stage. It takes the same signed 32-bit operand pair as the ALU, but across a valid/ready handshake, and holds the result until the pipeline accepts it. While it is busy, the hazard unit stalls IF/ID/EX. Flush from branch resolution aborts an in-flight operation.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width. Only 32 is supported.

Ports:
- `clk` in 1: rising-edge clock.
- `rstn` in 1: asynchronous active-low reset.
- `in_valid` in 1: operands and op are valid.
- `in_ready` out 1: unit is idle and can accept.
- `MDUOp` in 3: operation select. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `A` in XLEN: rs1 operand.
- `B` in XLEN: rs2 operand.
- `flush` in 1: abort the current operation.
- `out_valid` out 1: `C_out` holds the result.
- `out_ready` in 1: the consumer takes the result.
- `C_out` out XLEN: result.
- `busy` out 1: high in any state except IDLE.

## Operation
- States are IDLE, CALC, SIGN and DONE; MUL2 exists only with the macro.
- Accept happens on an edge where `in_valid & in_ready & !flush`. On accept, latch `MDUOp`, the absolute values of the operands, and the result sign.
- IDLE -> CALC on accept. CALC runs 32 iterations, one bit per cycle, driven by a 5-bit counter that counts up from 0. CALC -> SIGN when the counter reaches 31.
  - Multiply: shift-add into a 64-bit product.
  - Divide: restoring, 1 quotient bit per cycle.
- SIGN applies two's-complement negation where the op requires it and selects the high or low word (quotient or remainder). Then SIGN -> DONE.
- DONE: `out_valid` is 1 and `C_out` is stable. DONE -> IDLE on `out_ready`.
- Special cases bypass CALC and go IDLE -> DONE directly:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give A.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
- Sign rules:
  - MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - The quotient sign is A[31]^B[31]; the remainder takes A's sign.
- `flush` in any state forces IDLE on the next edge and clears `out_valid`. `flush` beats `in_valid` in the same cycle, so nothing is accepted.
- Reset (async, any state) gives IDLE, counter 0, `out_valid`=0, `C_out`=0, `busy`=0, `in_ready`=1.
- `in_ready` = (state==IDLE); it is combinational from state.

## Timing
- Normal op: accept on edge E0, CALC over E1..E32, SIGN at E33. `out_valid` rises after E34 (34 edges after accept).
- Special case: `out_valid` rises after the edge following accept (latency 1).
- `out_valid` holds with `C_out` constant until `out_ready` is high on an edge. No back-to-back accept: the earliest next accept is the edge after DONE->IDLE.
- `out_ready` with `out_valid` low is ignored.

## Configuration
- `MDU_FAST_MUL_EN` defined: MUL* ops use a single 33x33 signed combinational multiply registered into MUL2. Path is IDLE -> MUL2 -> DONE, latency 2. Divides are unchanged.
- Undefined: all ops use the iterative path. No multiplier is inferred.

## Structure
- `MDUOp_*` encodings go in `ctrl_encode_def.v` next to the `ALUOp_*` codes.
- Data width comes from `DATA_BUS_WIDTH` in `bus.v`.
- One sub-module, `mdu_div_core`: restoring divider step datapath (remainder/quotient registers and the per-cycle subtract). The FSM and sign handling stay in `mdu`.

## Test plan
- MUL A=7, B=-3 -> `C_out`=0xFFFFFFEB, `out_valid` 34 edges after accept (2 with `MDU_FAST_MUL_EN`). MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each at latency 1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- Hold `out_ready`=0 for 10 cycles after DONE -> `out_valid` and `C_out` stable, `in_ready`=0, and a new `in_valid` is not accepted.
- `flush` at CALC cycle 10 -> IDLE next edge, `out_valid` never rises, and a following DIVU 9/3 returns 3.
- Deassert `rstn` mid-CALC asynchronously -> `busy`=0 and `out_valid`=0 immediately. After release, MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared RV32M op encodings, FSM state type and operand helpers for the mdu.
// MDU_FAST_MUL_EN adds the MUL2 state used by the single-step multiplier path.
package mdu_pkg;

  localparam int XLEN_C = 32;

  localparam logic [2:0] MDU_OP_MUL    = 3'd0;
  localparam logic [2:0] MDU_OP_MULH   = 3'd1;
  localparam logic [2:0] MDU_OP_MULHSU = 3'd2;
  localparam logic [2:0] MDU_OP_MULHU  = 3'd3;
  localparam logic [2:0] MDU_OP_DIV    = 3'd4;
  localparam logic [2:0] MDU_OP_DIVU   = 3'd5;
  localparam logic [2:0] MDU_OP_REM    = 3'd6;
  localparam logic [2:0] MDU_OP_REMU   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_SIGN = 3'd2,
    ST_DONE = 3'd3
`ifdef MDU_FAST_MUL_EN
    , ST_MUL2 = 3'd4
`endif
  } mdu_state_t;

  function automatic logic [XLEN_C-1:0] neg2c(input logic [XLEN_C-1:0] v);
    return ~v + {{(XLEN_C-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider datapath: one quotient bit per step, operands unsigned, 1-cycle step.
// No handshake; the mdu FSM drives load/step and reads quo/rem when it is done.
module mdu_div_core
  import mdu_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic              step,
  input  logic [XLEN_C-1:0] dividend,
  input  logic [XLEN_C-1:0] divisor,
  output logic [XLEN_C-1:0] quo,
  output logic [XLEN_C-1:0] rem
);

  logic [XLEN_C-1:0] quo_q, quo_d;
  logic [XLEN_C-1:0] rem_q, rem_d;
  logic [XLEN_C:0]   shifted;
  logic              fits;

  always_comb begin
    shifted = {rem_q, quo_q[XLEN_C-1]};
    fits    = (shifted >= {1'b0, divisor});
    quo_d   = quo_q;
    rem_d   = rem_q;
    if (load) begin
      quo_d = dividend;
      rem_d = '0;
    end else if (step) begin
      // A successful subtract always leaves a value below the divisor, so 32 bits hold it.
      rem_d = fits ? (shifted[XLEN_C-1:0] - divisor) : shifted[XLEN_C-1:0];
      quo_d = {quo_q[XLEN_C-2:0], fits};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      quo_q <= '0;
      rem_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
    end
  end

  assign quo = quo_q;
  assign rem = rem_q;

endmodule

// File: rtl/mdu.sv
// Iterative RV32M mul/div: 34 edges to out_valid (1 for div special cases, 2 for MUL* with
// MDU_FAST_MUL_EN); accepts only when idle and holds C_out until out_ready; flush aborts.
module mdu
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      MDUOp,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] C_out,
  output logic            busy
);

  mdu_state_t  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        neg_q, neg_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] c_out_q, c_out_d;
  logic        out_valid_q, out_valid_d;

  logic        accept, a_sgn, b_sgn, neg_in, div_zero, div_ovf;
  logic [31:0] a_in, b_in, special_res, div_quo, div_rem, div_word, div_res, mul_word;
  logic [32:0] mul_sum;
  logic [63:0] mul_full;

  assign accept = in_valid & (state_q == ST_IDLE) & ~flush;

  always_comb begin
    a_sgn = (MDUOp == MDU_OP_MULH) | (MDUOp == MDU_OP_MULHSU) |
            (MDUOp == MDU_OP_DIV)  | (MDUOp == MDU_OP_REM);
    b_sgn = (MDUOp == MDU_OP_MULH) | (MDUOp == MDU_OP_DIV) | (MDUOp == MDU_OP_REM);
    a_in  = (a_sgn & A[31]) ? neg2c(A) : A;
    b_in  = (b_sgn & B[31]) ? neg2c(B) : B;
    // Remainder follows the dividend; everything else takes the product/quotient sign.
    neg_in = (MDUOp == MDU_OP_REM) ? A[31] : ((a_sgn & A[31]) ^ (b_sgn & B[31]));
    div_zero = MDUOp[2] & (B == 32'd0);
    div_ovf  = ((MDUOp == MDU_OP_DIV) | (MDUOp == MDU_OP_REM)) &
               (A == 32'h8000_0000) & (B == 32'hFFFF_FFFF);
    if (div_zero) special_res = MDUOp[1] ? A : 32'hFFFF_FFFF;
    else          special_res = MDUOp[1] ? 32'd0 : 32'h8000_0000;
  end

  always_comb begin
    mul_sum  = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, a_q} : 33'd0);
    mul_full = neg_q ? (~prod_q + 64'd1) : prod_q;
    mul_word = (op_q == MDU_OP_MUL) ? mul_full[31:0] : mul_full[63:32];
    div_word = op_q[1] ? div_rem : div_quo;
    div_res  = neg_q ? neg2c(div_word) : div_word;
  end

`ifdef MDU_FAST_MUL_EN
  logic [32:0] fa, fb;
  logic [63:0] fprod;

  always_comb begin
    fa    = {(MDUOp != MDU_OP_MULHU) & A[31], A};
    fb    = {((MDUOp == MDU_OP_MUL) | (MDUOp == MDU_OP_MULH)) & B[31], B};
    fprod = {{31{fa[32]}}, fa} * {{31{fb[32]}}, fb};
  end
`endif

  mdu_div_core u_div (
    .clk      (clk),
    .rstn     (rstn),
    .load     (accept),
    .step     ((state_q == ST_CALC) & op_q[2]),
    .dividend (a_in),
    .divisor  (b_q),
    .quo      (div_quo),
    .rem      (div_rem)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    neg_d       = neg_q;
    prod_d      = prod_q;
    c_out_d     = c_out_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = MDUOp;
          a_d    = a_in;
          b_d    = b_in;
          neg_d  = neg_in;
          cnt_d  = 5'd0;
          prod_d = {32'd0, b_in};
          if (div_zero | div_ovf) begin
            c_out_d = special_res;
            state_d = ST_DONE;
          end
`ifdef MDU_FAST_MUL_EN
          else if (!MDUOp[2]) begin
            prod_d  = fprod;
            state_d = ST_MUL2;
          end
`endif
          else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (!op_q[2]) prod_d = {mul_sum, prod_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ST_SIGN;
      end
      ST_SIGN: begin
        c_out_d = op_q[2] ? div_res : mul_word;
        state_d = ST_DONE;
      end
`ifdef MDU_FAST_MUL_EN
      ST_MUL2: begin
        c_out_d = (op_q == MDU_OP_MUL) ? prod_q[31:0] : prod_q[63:32];
        state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        // out_valid trails entry to DONE by one edge; a handshake needs it already high.
        if (out_valid_q & out_ready) state_d = ST_IDLE;
        else                         out_valid_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d     = ST_IDLE;
      cnt_d       = 5'd0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 5'd0;
      op_q        <= 3'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      neg_q       <= 1'b0;
      prod_q      <= 64'd0;
      c_out_q     <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      neg_q       <= neg_d;
      prod_q      <= prod_d;
      c_out_q     <= c_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign C_out     = c_out_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: expected results queued at issue, popped when out_valid rises.
module tb_mdu;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic        clk, rstn, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [2:0]  MDUOp;
  logic [31:0] A, B, C_out;

  logic [31:0] exp_q[$];
  int          n_cmp, n_err;

  mdu #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .MDUOp(MDUOp),
    .A(A), .B(B), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .C_out(C_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, b);
    longint      sa, sb, ub, r;
    logic [63:0] pu, rv;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    pu  = {32'd0, a} * {32'd0, b};
    r   = 0;
    case (op)
      3'd0: r = sa * sb;
      3'd1: r = (sa * sb) >>> 32;
      3'd2: r = (sa * ub) >>> 32;
      3'd3: r = longint'(pu >> 32);
      3'd4: r = (b == 0) ? -1 : (ovf ? longint'(32'h8000_0000) : sa / sb);
      3'd5: r = (b == 0) ? -1 : longint'(a / b);
      3'd6: r = (b == 0) ? sa : (ovf ? 0 : sa % sb);
      default: r = (b == 0) ? longint'(a) : longint'(a % b);
    endcase
    rv = r;
    return rv[31:0];
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, b);
    if (op[2] && (b == 32'd0)) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return op[2] ? DIV_LAT : MUL_LAT;
  endfunction

  // Drives one request at a negedge; the following posedge is the accept edge.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, b,
                          input logic [31:0] exp, input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    in_valid = 1'b1; MDUOp = op; A = a; B = b;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic finish_op(input int lat, input int hold, input string tag);
    int          n;
    logic [31:0] exp, held;
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_res"}, C_out, exp);
    held = C_out;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; MDUOp = 3'd5; A = 32'd77; B = 32'd7;
      @(negedge clk);
      check({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_c"}, C_out, held);
      check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drain"}, {30'd0, busy, out_valid}, 32'd0);
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, b,
                     input logic [31:0] exp, input int lat, input string tag);
    start_op(op, a, b, exp, 1'b1);
    finish_op(lat, 0, tag);
  endtask

  initial begin
    bit          seen;
    logic [2:0]  op;
    logic [31:0] ra, rb;
    n_cmp = 0; n_err = 0;
    rstn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    MDUOp = 3'd0; A = 32'd0; B = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_c_out", C_out, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    run(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul_7x-3");
    start_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    finish_op(MUL_LAT, 10, "mulhu_hold");
    run(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT, "div_-7/2");
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT, "rem_-7/2");
    run(3'd5, 32'd100, 32'd7, 32'd14, DIV_LAT, "divu_100/7");
    run(3'd7, 32'd100, 32'd7, 32'd2, DIV_LAT, "remu_100/7");
    run(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_by0");
    out_ready = 1'b1;  // held high before out_valid: must not drain early
    run(3'd6, 32'd5, 32'd0, 32'd5, 1, "rem_by0");
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
    start_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
    finish_op(DIV_LAT, 10, "div_hold");

    // flush wins over a simultaneous request
    in_valid = 1'b1; MDUOp = 3'd5; A = 32'd9; B = 32'd3; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_beats_vld", 32'(busy), 32'd0);

    start_op(3'd5, 32'd1000, 32'd3, 32'd0, 1'b0);
    repeat (10) @(negedge clk);
    check("calc_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", {30'd0, busy, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    check("flush_no_vld", 32'(seen), 32'd0);
    run(3'd5, 32'd9, 32'd3, 32'd3, DIV_LAT, "divu_after_flush");

    start_op(3'd5, 32'd123, 32'd4, 32'd0, 1'b0);
    repeat (5) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_c_out", C_out, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT, "mulhsu_after_rst");
    run(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, "mulh_min");

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (i == 5) begin op = 3'd4; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if (i % 4 == 1) rb = rb >> $urandom_range(1, 28);
      run(op, ra, rb, model(op, ra, rb), lat_of(op, ra, rb), "rnd");
    end

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
